// File: rtl/dmem_access_ctrl_if.sv
// Handshaked data-memory bus between the MEM-stage access controller and data memory.
// The controller drives requests; the memory returns ready and read data.
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one request/ready transaction per access, stalls the
// pipeline while it is outstanding, and handles lane alignment, extension, misalign and timeout.
module dmem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RegWrite_M,
    input  logic                       MemWrite_M,
    input  logic [1:0]                 ResultSrc_M,
    input  logic [1:0]                 SizeSrc_M,
    input  logic                       LoadSign_M,
    input  logic [31:0]                ALUResult_M,
    input  logic [31:0]                WriteData_M,
    dmem_access_ctrl_if.master         bus,
    output logic [31:0]                ReadData_M,
    output logic                       RegWrite_M_out,
    output logic                       Stall_M,
    output logic                       MisalignFault,
    output logic                       BusError
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_WAIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic [1:0]      off_q, off_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic            buserr_q, buserr_d;

    logic        mem_op;
    logic        misaligned;
    logic        in_idle;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_fmt;

    assign mem_op     = MemWrite_M | (ResultSrc_M == 2'b01);
    assign misaligned = ((SizeSrc_M == 2'b01) & ALUResult_M[0]) |
                        (SizeSrc_M[1] & (ALUResult_M[1:0] != 2'b00));
    assign in_idle    = (state_q == StIdle);

    assign Stall_M        = (in_idle & mem_op & ~misaligned) | (state_q == StBusy);
    assign RegWrite_M_out = RegWrite_M & ~Stall_M & ~(in_idle & mem_op & misaligned);

    // Store lanes are replicated so the strobes alone pick the bytes written.
    always_comb begin
        st_strb = 4'b1111;
        st_data = WriteData_M;
        case (SizeSrc_M)
            2'b00: begin
                st_strb = 4'b0001 << ALUResult_M[1:0];
                st_data = {4{WriteData_M[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << ALUResult_M[1:0];
                st_data = {2{WriteData_M[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = WriteData_M;
            end
        endcase
    end

    always_comb begin
        byte_lane = bus.mem_rdata[7:0];
        case (off_q)
            2'd0:    byte_lane = bus.mem_rdata[7:0];
            2'd1:    byte_lane = bus.mem_rdata[15:8];
            2'd2:    byte_lane = bus.mem_rdata[23:16];
            default: byte_lane = bus.mem_rdata[31:24];
        endcase
        half_lane = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_fmt = {{24{sign_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_fmt = {{16{sign_q & half_lane[15]}}, half_lane};
            default: load_fmt = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        size_d     = size_q;
        sign_d     = sign_q;
        off_d      = off_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_op && misaligned) begin
                    misalign_d = 1'b1;
                end else if (mem_op) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    we_d    = MemWrite_M;
                    addr_d  = {ALUResult_M[31:2], 2'b00};
                    wdata_d = st_data;
                    wstrb_d = MemWrite_M ? st_strb : 4'b0000;
                    size_d  = SizeSrc_M;
                    sign_d  = LoadSign_M;
                    off_d   = ALUResult_M[1:0];
                    wait_d  = '0;
                end
            end
            StBusy: begin
                if (wait_q != MaxCnt) begin
                    wait_d = wait_q + CntW'(1);
                end
                // A ready arriving on the final count takes priority over the timeout.
                if (bus.mem_ready) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    wait_d  = wait_q;
                    if (!we_q) begin
                        rdata_d = load_fmt;
                    end
                end else if (wait_q >= LastCnt) begin
                    state_d  = StDone;
                    req_d    = 1'b0;
                    buserr_d = 1'b1;
                    rdata_d  = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            off_q      <= '0;
            wait_q     <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            off_q      <= off_d;
            wait_q     <= wait_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign ReadData_M    = rdata_q;
    assign MisalignFault = misalign_q;
    assign BusError      = buserr_q;

endmodule
